operand_entry: RTL and testbench
================================

OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DEBOUNCE, default 250000, cycles valid must hold stable before a key is accepted (5 ms at 50 MHz).
REQ-002 Parameter RELEASE, default 250000, cycles valid must stay low before the next key is armed.
REQ-003 clk  in  1  system clock, 50 MHz, all state on rising edge; one clock only.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 value  in  4  decoded key code from the keypad stage (0-9 digits, 10-13 A-D, 14 '*', 15 '#').
REQ-006 valid  in  1  level, high while a decoded key is present; not synchronised to clk.
REQ-007 operand  out  16  four-digit BCD operand, digit 3 in [15:12], least significant digit in [3:0].
REQ-008 digits  out  3  count of digits entered, 0-4.
REQ-009 op  out  2  operator code: A=00 add, B=01 sub, C=10 mul, D=11 div.
REQ-010 op_strobe  out  1  one-cycle pulse, operator key accepted.
REQ-011 eq_strobe  out  1  one-cycle pulse, '#' accepted.
REQ-012 clr_strobe  out  1  one-cycle pulse, '*' accepted.

Function
REQ-013 valid and value SHALL pass through a two-flop synchroniser before any use; all timing below counts from synchronised signals.
REQ-014 Press FSM states SHALL be IDLE, DEBOUNCE, ACCEPT, HELD, WAIT_RELEASE.
REQ-015 IDLE: valid high -> DEBOUNCE, latch value as candidate, counter = 0.
REQ-016 DEBOUNCE: valid low -> IDLE; value differs from candidate -> re-latch candidate, counter = 0, stay; counter reaching DEBOUNCE-1 -> ACCEPT; else counter increments.
REQ-017 ACCEPT SHALL last exactly one cycle, then HELD; the candidate is acted on exactly once per press.
REQ-018 HELD: valid low -> WAIT_RELEASE with counter = 0; value changes while held are ignored.
REQ-019 WAIT_RELEASE: valid high -> HELD; counter reaching RELEASE-1 -> IDLE.
REQ-020 Digit accepted with digits<4: operand shifts left one BCD digit, new digit enters [3:0], digits increments; visible the cycle after ACCEPT.
REQ-021 Digit accepted with digits=4: operand and digits SHALL be unchanged (fifth digit dropped).
REQ-022 Leading zero with digits=0 SHALL leave digits at 0 and operand at 0.
REQ-023 Operator accepted: op updated and op_strobe high for one cycle, the cycle after ACCEPT, with operand/digits still holding the entered value.
REQ-024 '#' accepted: eq_strobe high for one cycle with operand held, same timing as op_strobe.
REQ-025 Cycle after op_strobe or eq_strobe: operand and digits SHALL clear to 0; op retains its value.
REQ-026 '*' accepted: clr_strobe high one cycle; operand and digits clear on that same strobe cycle; op resets to 00.
REQ-027 At most one strobe SHALL be high in any cycle.
REQ-028 Counters SHALL saturate, never wrap, and be sized to ceil(log2(max(DEBOUNCE,RELEASE)+1)).

Reset
REQ-029 rst high SHALL immediately force FSM to IDLE, counters to 0, operand=0, digits=0, op=00, all strobes 0, synchroniser flops to 0.
REQ-030 Reset asserted mid-press: after release the still-held key SHALL re-enter DEBOUNCE from IDLE and be accepted once after DEBOUNCE cycles.

Verification (DEBOUNCE=RELEASE=4)
REQ-031 Press 1, 2, 3 each held 10 cycles, released 10 cycles -> operand=0x0123, digits=3, no strobes.
REQ-032 valid pulses high 3 cycles then low (bounce) -> no digit accepted, FSM back to IDLE, operand unchanged.
REQ-033 Enter 9,8,7,6,5 -> operand=0x9876, digits=4 after fifth press.
REQ-034 Enter 4,2 then key 11 -> op_strobe one cycle with operand=0x0042, op=01; next cycle operand=0, digits=0.
REQ-035 Hold key 7 for 100 cycles -> exactly one digit accepted; release gap of 2 cycles then re-press -> no second accept.
REQ-036 Enter 5, key 14 -> clr_strobe one cycle, operand=0, digits=0, op=00; assert rst mid-DEBOUNCE -> all outputs 0 same cycle.

Source files
------------

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - keypad operand entry: synchroniser, press debouncer, BCD operand builder
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   value[3:0]  decoded key code (0-9 digit, 10-13 A-D operator, 14 '*', 15 '#'), asynchronous
//   valid       high while a decoded key is present, asynchronous
//   operand     four-digit BCD operand, most significant digit in [15:12]
//   digits      number of digits entered, 0-4
//   op          operator code: 00 add, 01 sub, 10 mul, 11 div
//   op_strobe   one-cycle pulse when an operator key is accepted
//   eq_strobe   one-cycle pulse when '#' is accepted
//   clr_strobe  one-cycle pulse when '*' is accepted
module operand_entry #(
  parameter int DEBOUNCE = 250000,
  parameter int RELEASE  = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  value,
  input  logic        valid,
  output logic [15:0] operand,
  output logic [2:0]  digits,
  output logic [1:0]  op,
  output logic        op_strobe,
  output logic        eq_strobe,
  output logic        clr_strobe
);

  localparam int CNT_LIMIT = (DEBOUNCE > RELEASE) ? DEBOUNCE : RELEASE;
  localparam int CW        = $clog2(CNT_LIMIT + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ACCEPT,
    S_HELD,
    S_WAIT_RELEASE
  } state_t;

  logic          valid_s1, valid_s2;
  logic [3:0]    value_s1, value_s2;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;

  // Two-flop synchroniser; nothing downstream looks at the raw inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
      value_s1 <= 4'd0;
      value_s2 <= 4'd0;
    end else begin
      valid_s1 <= valid;
      valid_s2 <= valid_s1;
      value_s1 <= value;
      value_s2 <= value_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Saturating increment: the counter holds at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      S_IDLE: begin
        if (valid_s2) begin
          state_d = S_DEBOUNCE;
          cand_d  = value_s2;
          cnt_d   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!valid_s2) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (value_s2 != cand_q) begin
          // A different key appeared mid-bounce: restart on the new code.
          cand_d = value_s2;
          cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_ACCEPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ACCEPT: begin
        state_d = S_HELD;
        cnt_d   = '0;
      end
      S_HELD: begin
        if (!valid_s2) begin
          state_d = S_WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      S_WAIT_RELEASE: begin
        if (valid_s2) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (cnt_q == REL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Key actions register on the edge that leaves ACCEPT, so their effect is
  // visible in the first HELD cycle. Strobes are spaced by at least one full
  // press, so the post-strobe clear never collides with a new action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand    <= 16'd0;
      digits     <= 3'd0;
      op         <= 2'b00;
      op_strobe  <= 1'b0;
      eq_strobe  <= 1'b0;
      clr_strobe <= 1'b0;
    end else begin
      op_strobe  <= 1'b0;
      eq_strobe  <= 1'b0;
      clr_strobe <= 1'b0;
      if (op_strobe || eq_strobe) begin
        operand <= 16'd0;
        digits  <= 3'd0;
      end
      if (state_q == S_ACCEPT) begin
        if (cand_q <= 4'd9) begin
          // Fifth digit and leading zeros are dropped.
          if (digits < 3'd4 && !(digits == 3'd0 && cand_q == 4'd0)) begin
            operand <= {operand[11:0], cand_q};
            digits  <= digits + 3'd1;
          end
        end else if (cand_q == 4'd14) begin
          operand    <= 16'd0;
          digits     <= 3'd0;
          op         <= 2'b00;
          clr_strobe <= 1'b1;
        end else if (cand_q == 4'd15) begin
          eq_strobe <= 1'b1;
        end else begin
          // Codes 10..13 map to 00..11; subtracting 2 from the low bits does that.
          op        <= cand_q[1:0] - 2'd2;
          op_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - self-checking bench for operand_entry
module tb_operand_entry;

  localparam int D = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  value = 4'd0;
  logic        valid = 1'b0;
  logic [15:0] operand;
  logic [2:0]  digits;
  logic [1:0]  op;
  logic        op_strobe, eq_strobe, clr_strobe;

  operand_entry #(.DEBOUNCE(D), .RELEASE(R)) dut (
    .clk(clk), .rst(rst), .value(value), .valid(valid),
    .operand(operand), .digits(digits), .op(op),
    .op_strobe(op_strobe), .eq_strobe(eq_strobe), .clr_strobe(clr_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the operand is kept as a decimal number; key acceptance is
  // judged from run lengths of the synchronised inputs.
  logic       m_d1v, m_d2v;
  logic [3:0] m_d1val, m_d2val;
  bit         m_armed, m_pend;
  int         m_run, m_lows;
  logic [3:0] m_cand;
  int         e_num, e_digits;
  int         e_op;
  bit         e_ops, e_eqs, e_clrs;

  typedef struct {
    logic [3:0]  key;
    int          hold;
    int          gap;
    logic [15:0] exp_operand;
    int          exp_digits;
    int          exp_op;
  } vec_t;

  function automatic logic [15:0] bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1v = 0; m_d2v = 0; m_d1val = 0; m_d2val = 0;
    m_armed = 1; m_pend = 0; m_run = 0; m_lows = 0; m_cand = 0;
    e_num = 0; e_digits = 0; e_op = 0; e_ops = 0; e_eqs = 0; e_clrs = 0;
  endtask

  task automatic apply_key(input int key);
    if (key <= 9) begin
      if (e_digits < 4 && !(e_digits == 0 && key == 0)) begin
        e_num = e_num * 10 + key;
        e_digits++;
      end
    end else if (key == 14) begin
      e_num = 0; e_digits = 0; e_op = 0; e_clrs = 1;
    end else if (key == 15) begin
      e_eqs = 1;
    end else begin
      e_op = key - 10; e_ops = 1;
    end
  endtask

  task automatic model_edge();
    logic       sv;
    logic [3:0] sval;
    sv = m_d2v; sval = m_d2val;
    m_d2v = m_d1v; m_d2val = m_d1val;
    m_d1v = valid; m_d1val = value;
    if (e_ops || e_eqs) begin
      e_num = 0; e_digits = 0;
    end
    e_ops = 0; e_eqs = 0; e_clrs = 0;
    if (m_pend) begin
      m_pend = 0; m_lows = 0;
      apply_key(int'(m_cand));
    end else if (!m_armed) begin
      if (sv) m_lows = 0;
      else m_lows++;
      if (m_lows == R + 1) begin
        m_armed = 1; m_run = 0;
      end
    end else if (sv) begin
      m_run = (m_run > 0 && sval == m_cand) ? m_run + 1 : 1;
      m_cand = sval;
      if (m_run == D + 1) begin
        m_pend = 1; m_armed = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    chk("operand", int'(operand), int'(bcd(e_num)));
    chk("digits", int'(digits), e_digits);
    chk("op", int'(op), e_op);
    chk("strobes", int'({op_strobe, eq_strobe, clr_strobe}), int'({e_ops, e_eqs, e_clrs}));
    chk("one_strobe", int'($countones({op_strobe, eq_strobe, clr_strobe}) <= 1), 1);
  endtask

  task automatic press(input logic [3:0] key, input int hold, input int gap);
    value = key; valid = 1'b1;
    repeat (hold) tick();
    valid = 1'b0;
    repeat (gap) tick();
  endtask

  vec_t tbl[$];
  bit   found;

  initial begin
    model_reset();
    tbl.push_back('{4'd1,  10, 10, 16'h0001, 1, 0});
    tbl.push_back('{4'd2,  10, 10, 16'h0012, 2, 0});
    tbl.push_back('{4'd3,  10, 10, 16'h0123, 3, 0});
    tbl.push_back('{4'd14, 10, 10, 16'h0000, 0, 0});
    tbl.push_back('{4'd9,  10, 10, 16'h0009, 1, 0});
    tbl.push_back('{4'd8,  10, 10, 16'h0098, 2, 0});
    tbl.push_back('{4'd7,  10, 10, 16'h0987, 3, 0});
    tbl.push_back('{4'd6,  10, 10, 16'h9876, 4, 0});
    tbl.push_back('{4'd5,  10, 10, 16'h9876, 4, 0});
    tbl.push_back('{4'd14, 10, 10, 16'h0000, 0, 0});
    tbl.push_back('{4'd0,  10, 10, 16'h0000, 0, 0});
    tbl.push_back('{4'd4,  10, 10, 16'h0004, 1, 0});
    tbl.push_back('{4'd2,  10, 10, 16'h0042, 2, 0});
    tbl.push_back('{4'd11, 10, 10, 16'h0000, 0, 1});
    tbl.push_back('{4'd15, 10, 10, 16'h0000, 0, 1});
    tbl.push_back('{4'd12, 10, 10, 16'h0000, 0, 2});

    // Reset state
    repeat (2) tick();
    chk("rst_operand", int'(operand), 0);
    chk("rst_digits", int'(digits), 0);
    chk("rst_op", int'(op), 0);
    chk("rst_strobes", int'({op_strobe, eq_strobe, clr_strobe}), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Directed key table
    for (int i = 0; i < tbl.size(); i++) begin
      press(tbl[i].key, tbl[i].hold, tbl[i].gap);
      chk($sformatf("tbl%0d_operand", i), int'(operand), int'(tbl[i].exp_operand));
      chk($sformatf("tbl%0d_digits", i), int'(digits), tbl[i].exp_digits);
      chk($sformatf("tbl%0d_op", i), int'(op), tbl[i].exp_op);
    end

    // Operator strobe timing: operand held on the strobe cycle, cleared after
    press(4'd4, 10, 10);
    press(4'd2, 10, 10);
    value = 4'd11; valid = 1'b1; found = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (op_strobe) begin found = 1; break; end
    end
    chk("op_strobe_seen", int'(found), 1);
    chk("op_strobe_operand", int'(operand), 16'h0042);
    chk("op_strobe_op", int'(op), 1);
    tick();
    chk("after_op_operand", int'(operand), 0);
    chk("after_op_digits", int'(digits), 0);
    valid = 1'b0;
    repeat (10) tick();

    // Bounce: 3 cycles high is not enough
    value = 4'd3; valid = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    repeat (10) tick();
    chk("bounce_digits", int'(digits), 0);
    chk("bounce_operand", int'(operand), 0);
    press(4'd3, 10, 10);
    chk("after_bounce_operand", int'(operand), 16'h0003);

    // Long hold, short release gap: one accept only
    press(4'd14, 10, 10);
    value = 4'd7; valid = 1'b1;
    repeat (100) tick();
    valid = 1'b0;
    repeat (2) tick();
    valid = 1'b1;
    repeat (20) tick();
    valid = 1'b0;
    repeat (10) tick();
    chk("hold_digits", int'(digits), 1);
    chk("hold_operand", int'(operand), 16'h0007);

    // Clear: strobe cycle already shows zeros and op reset
    press(4'd11, 10, 10);
    press(4'd5, 10, 10);
    value = 4'd14; valid = 1'b1; found = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (clr_strobe) begin found = 1; break; end
    end
    chk("clr_strobe_seen", int'(found), 1);
    chk("clr_operand", int'(operand), 0);
    chk("clr_digits", int'(digits), 0);
    chk("clr_op", int'(op), 0);
    valid = 1'b0;
    repeat (10) tick();

    // Reset mid-DEBOUNCE, key still held afterwards gets accepted once
    press(4'd13, 10, 10);
    press(4'd5, 10, 10);
    value = 4'd6; valid = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_operand", int'(operand), 0);
    chk("async_rst_digits", int'(digits), 0);
    chk("async_rst_op", int'(op), 0);
    chk("async_rst_strobes", int'({op_strobe, eq_strobe, clr_strobe}), 0);
    model_reset();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("rearm_digits", int'(digits), 1);
    chk("rearm_operand", int'(operand), 16'h0006);
    valid = 1'b0;
    repeat (10) tick();
    chk("rearm_once", int'(digits), 1);

    // Randomised presses, bounces and key changes against the model
    for (int i = 0; i < 80; i++) begin
      value = 4'($urandom_range(0, 15)); valid = 1'b1;
      repeat ($urandom_range(1, 12)) tick();
      if ($urandom_range(0, 2) == 0) begin
        value = 4'($urandom_range(0, 15));
        repeat ($urandom_range(1, 8)) tick();
      end
      valid = 1'b0;
      value = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 10)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
